// File: rtl/pixel_packer.sv
// Packs the filter's {valid, pixel} stream into 32-bit words, buffers them in a small FIFO
// and drains them to SRAM port 1. Optional macro PIXEL_PACKER_BYTE_SWAP_EN reverses lane order.
module pixel_packer #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reflesh,
  input  logic [DATA_WIDTH-1:0]    image_size,
  input  logic [8:0]               data_in,
  input  logic                     ready,
  output logic                     request,
  output logic                     command_entry,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     is_end,
  output logic                     overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    size_q, size_d;
  logic [DATA_WIDTH-1:0]    byte_cnt_q, byte_cnt_d;
  logic [1:0]               lane_q, lane_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                     full_q, full_d, empty_q, empty_d;
  logic [ADDRESS_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     cmd_q, cmd_d;
  logic                     request_q, request_d;
  logic                     is_end_q, is_end_d;
  logic                     overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

  logic                     accept_c, last_c, word_done_c, push_c, pop_c;
  logic [1:0]               lane_pos_c;
  logic [DATA_WIDTH-1:0]    merged_c;

`ifdef PIXEL_PACKER_BYTE_SWAP_EN
  assign lane_pos_c = 2'(2'd3 - lane_q);
`else
  assign lane_pos_c = lane_q;
`endif

  // Next-state: packing, FIFO bookkeeping, write issue and frame control
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    byte_cnt_d  = byte_cnt_q;
    lane_d      = lane_q;
    word_d      = word_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    full_d      = full_q;
    empty_d     = empty_q;
    wr_idx_d    = wr_idx_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    cmd_d       = 1'b0;
    request_d   = request_q;
    is_end_d    = is_end_q;
    overflow_d  = overflow_q;
    word_done_c = 1'b0;
    last_c      = 1'b0;
    push_c      = 1'b0;
    merged_c    = word_q | (DATA_WIDTH'(data_in[7:0]) << {lane_pos_c, 3'b000});
    accept_c    = (state_q == RUN) && data_in[8];
    pop_c       = ready && !empty_q;

    if (accept_c) begin
      byte_cnt_d = byte_cnt_q + DATA_WIDTH'(1);
      last_c     = (byte_cnt_q + DATA_WIDTH'(1)) >= size_q;
      if ((lane_q == 2'd3) || last_c) begin
        word_done_c = 1'b1;
        word_d      = '0;
        lane_d      = 2'd0;
      end else begin
        word_d = merged_c;
        lane_d = 2'(lane_q + 2'd1);
      end
    end

    push_c = word_done_c && (!full_q || pop_c);
    if (word_done_c && !push_c) overflow_d = 1'b1;

    if (pop_c) begin
      cmd_d    = 1'b1;
      dout_d   = mem_q[rd_ptr_q];
      addr_d   = wr_idx_q;
      wr_idx_d = wr_idx_q + ADDRESS_WIDTH'(1);
      rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
    end
    if (push_c) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));

    if (push_c && !pop_c) begin
      empty_d = 1'b0;
      full_d  = (PTR_W'(wr_ptr_q + PTR_W'(1)) == rd_ptr_q);
    end else if (pop_c && !push_c) begin
      full_d  = 1'b0;
      empty_d = (PTR_W'(rd_ptr_q + PTR_W'(1)) == wr_ptr_q);
    end

    case (state_q)
      RUN:     if (accept_c && last_c) state_d = DRAIN;
      DRAIN:   if (empty_q) state_d = DONE;
      default: state_d = state_q;
    endcase

    if ((state_d == DONE) && (state_q != DONE)) begin
      is_end_d  = 1'b1;
      request_d = 1'b0;
    end

    // Restart wins over everything, including a word completing on the same edge
    if (reflesh) begin
      size_d     = image_size;
      state_d    = (image_size == '0) ? DONE : RUN;
      byte_cnt_d = '0;
      lane_d     = 2'd0;
      word_d     = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      full_d     = 1'b0;
      empty_d    = 1'b1;
      wr_idx_d   = '0;
      addr_d     = '0;
      cmd_d      = 1'b0;
      overflow_d = 1'b0;
      is_end_d   = (image_size == '0);
      request_d  = (image_size != '0);
      push_c     = 1'b0;
      pop_c      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      size_q     <= '0;
      byte_cnt_q <= '0;
      lane_q     <= 2'd0;
      word_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      wr_idx_q   <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      cmd_q      <= 1'b0;
      request_q  <= 1'b0;
      is_end_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      wr_idx_q   <= wr_idx_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      cmd_q      <= cmd_d;
      request_q  <= request_d;
      is_end_q   <= is_end_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage needs no reset; the empty flag guards stale entries
  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_ptr_q] <= merged_c;
  end

  assign request       = request_q;
  assign command_entry = cmd_q;
  assign write_enable  = cmd_q;
  assign address       = addr_q;
  assign data_out      = dout_q;
  assign is_end        = is_end_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: frame model predicts SRAM writes, a monitor checks each pulse.
module tb_pixel_packer;

  logic        clock;
  logic        reset;
  logic        reflesh;
  logic [31:0] image_size;
  logic [8:0]  data_in;
  logic        ready;
  logic        request, command_entry, write_enable, is_end, overflow;
  logic [31:0] address, data_out;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  vectors    = 0;
  int  miscompares = 0;
  int  ready_mode = 0;
  int  low_run    = 0;

  pixel_packer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .reflesh(reflesh), .image_size(image_size),
    .data_in(data_in), .ready(ready), .request(request),
    .command_entry(command_entry), .write_enable(write_enable),
    .address(address), .data_out(data_out), .is_end(is_end), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Mode 0: always ready; 1: random with at most 3 low cycles in a row; 2: held low
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: ready = 1'b1;
      1: begin
        if (low_run >= 3 || $urandom_range(0, 1) == 1) begin
          ready = 1'b1;
          low_run = 0;
        end else begin
          ready = 1'b0;
          low_run++;
        end
      end
      default: ready = 1'b0;
    endcase
  end

  always @(negedge clock) begin : monitor
    wr_t e;
    if (reset === 1'b1) begin
      check("we_eq_cmd", 64'(write_enable), 64'(command_entry));
      if (command_entry === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", address, data_out);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 64'(address), 64'(e.addr));
          check("wr_data", 64'(data_out), 64'(e.data));
        end
      end
    end
  end

  // Reference: word w holds bytes 4w..4w+3 of the frame, only the first max_words survive
  function automatic void expect_frame(int size, logic [7:0] pix[$], int max_words);
    logic [31:0] w_data;
    int nwords;
    nwords = (size + 3) / 4;
    for (int w = 0; w < nwords && w < max_words; w++) begin
      w_data = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * w + j < size) begin
`ifdef PIXEL_PACKER_BYTE_SWAP_EN
          w_data[8*(3-j) +: 8] = pix[4*w+j];
`else
          w_data[8*j +: 8] = pix[4*w+j];
`endif
        end
      end
      sb.push_back({32'(w), w_data});
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input int size);
    image_size = 32'(size);
    data_in    = '0;
    reflesh    = 1'b1;
    tick();
    reflesh    = 1'b0;
  endtask

  task automatic send_pixels(input logic [7:0] pix[$], input bit gaps);
    foreach (pix[i]) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        data_in = '0;
        tick();
      end
      data_in = {1'b1, pix[i]};
      tick();
    end
    data_in = '0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (is_end !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_is_end"}, 64'(is_end), 64'd1);
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
    check({name, "_request"}, 64'(request), 64'd0);
  endtask

  initial begin
    logic [7:0] pix[$];
    logic [7:0] pix2[$];
    int size;
    reset      = 1'b0;
    reflesh    = 1'b0;
    image_size = '0;
    data_in    = '0;
    ready      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_request", 64'(request), 64'd0);
    check("rst_cmd", 64'(command_entry), 64'd0);
    check("rst_addr", 64'(address), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_is_end", 64'(is_end), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b1;
    tick();

    // Full words, back-to-back
    pix.delete();
    for (int i = 1; i <= 8; i++) pix.push_back(8'(i));
    expect_frame(8, pix, 1000);
    start_frame(8);
    check("a_request", 64'(request), 64'd1);
    send_pixels(pix, 1'b0);
    wait_end("a", 50);
    check("a_overflow", 64'(overflow), 64'd0);

    // Partial last word, extra pixels ignored
    pix.delete();
    for (int i = 0; i < 9; i++) pix.push_back(8'(8'hA1 + i));
    expect_frame(6, pix, 1000);
    start_frame(6);
    send_pixels(pix, 1'b0);
    wait_end("b", 50);
    check("b_overflow", 64'(overflow), 64'd0);

    // Random frames with gaps and bounded backpressure
    ready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      size = $urandom_range(1, 40);
      pix.delete();
      for (int i = 0; i < size + $urandom_range(0, 3); i++) pix.push_back(8'($urandom));
      expect_frame(size, pix, 1000);
      start_frame(size);
      send_pixels(pix, 1'b1);
      wait_end("rand", 400);
      check("rand_overflow", 64'(overflow), 64'd0);
    end

    // Backpressure: FIFO fills, words 5..8 dropped
    ready_mode = 2;
    tick();
    pix.delete();
    for (int i = 0; i < 32; i++) pix.push_back(8'($urandom));
    expect_frame(32, pix, 4);
    start_frame(32);
    send_pixels(pix, 1'b0);
    repeat (8) tick();
    check("c_overflow", 64'(overflow), 64'd1);
    check("c_not_end", 64'(is_end), 64'd0);
    ready_mode = 0;
    wait_end("c", 50);
    check("c_overflow_sticky", 64'(overflow), 64'd1);

    // Zero size: done immediately, never requests
    start_frame(0);
    check("z_is_end", 64'(is_end), 64'd1);
    check("z_request", 64'(request), 64'd0);
    repeat (5) tick();
    check("z_is_end_sticky", 64'(is_end), 64'd1);
    check("z_no_writes", 64'(sb.size()), 64'd0);

    // Reset mid-frame
    pix.delete();
    for (int i = 0; i < 3; i++) pix.push_back(8'(8'h30 + i));
    start_frame(8);
    send_pixels(pix, 1'b0);
    check("r_request_before", 64'(request), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("r_request", 64'(request), 64'd0);
    check("r_cmd", 64'(command_entry), 64'd0);
    check("r_we", 64'(write_enable), 64'd0);
    check("r_addr", 64'(address), 64'd0);
    check("r_is_end", 64'(is_end), 64'd0);
    check("r_overflow", 64'(overflow), 64'd0);
    tick();
    reset = 1'b1;
    repeat (20) tick();
    check("r_no_writes", 64'(sb.size()), 64'd0);
    check("r_idle_is_end", 64'(is_end), 64'd0);

    // Restart mid-frame discards the buffered word
    ready_mode = 2;
    tick();
    pix.delete();
    for (int i = 0; i < 5; i++) pix.push_back(8'(8'h50 + i));
    start_frame(8);
    send_pixels(pix, 1'b0);
    repeat (2) tick();
    pix2.delete();
    for (int i = 0; i < 4; i++) pix2.push_back(8'(8'h11 + i));
    expect_frame(4, pix2, 1000);
    start_frame(4);
    ready_mode = 0;
    check("g_addr_restart", 64'(address), 64'd0);
    send_pixels(pix2, 1'b0);
    wait_end("g", 50);
    check("g_overflow", 64'(overflow), 64'd0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
